// File: rtl/alu_cmd_sequencer_if.sv
// RX FIFO, ALU operand/result and UART TX signals of alu_cmd_sequencer.
// master = the sequencer, slave = the FIFO/ALU/UART side.
interface alu_cmd_sequencer_if #(
    parameter int N_DATA       = 8,
    parameter int NB_OPERATION = 6
);
    logic [N_DATA-1:0]       i_rx_data;
    logic                    i_rx_empty;
    logic                    o_rx_read;
    logic [N_DATA-1:0]       o_alu_data_a;
    logic [N_DATA-1:0]       o_alu_data_b;
    logic [NB_OPERATION-1:0] o_alu_data_op;
    logic [N_DATA-1:0]       i_alu_data;
    logic [N_DATA-1:0]       o_tx_data;
    logic                    o_tx_start;
    logic                    i_tx_done;
    logic                    o_busy;
    logic [7:0]              o_err_count;

    modport master (
        input  i_rx_data, i_rx_empty, i_alu_data, i_tx_done,
        output o_rx_read, o_alu_data_a, o_alu_data_b, o_alu_data_op,
               o_tx_data, o_tx_start, o_busy, o_err_count
    );

    modport slave (
        output i_rx_data, i_rx_empty, i_alu_data, i_tx_done,
        input  o_rx_read, o_alu_data_a, o_alu_data_b, o_alu_data_op,
               o_tx_data, o_tx_start, o_busy, o_err_count
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Framed UART command sequencer: SYNC, A, B, OP [, CHK] -> ALU -> result + status bytes.
// Define ALU_SEQ_CHECKSUM_EN to add the checksum byte (GET_CHK state).
//
// state       | meaning
// IDLE        | pop and discard bytes until SYNC_BYTE
// GET_A/B/OP  | pop operand A, operand B, opcode (inter-byte timeout active)
// GET_CHK     | pop and verify A ^ B ^ OP (checksum builds only)
// EXEC        | wait ALU_LATENCY cycles, capture ALU result
// SEND_RES    | transmit result byte
// SEND_STAT   | transmit status byte
module alu_cmd_sequencer #(
    parameter int                N_DATA         = 8,
    parameter int                NB_OPERATION   = 6,
    parameter logic [N_DATA-1:0] SYNC_BYTE      = 8'hA5,
    parameter int                TIMEOUT_CYCLES = 1000,
    parameter int                ALU_LATENCY    = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    alu_cmd_sequencer_if.master bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam int LAT_W = $clog2(ALU_LATENCY + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_A     = 3'd1,
        S_GET_B     = 3'd2,
        S_GET_OP    = 3'd3,
        S_EXEC      = 3'd4,
        S_SEND_RES  = 3'd5,
        S_SEND_STAT = 3'd6
`ifdef ALU_SEQ_CHECKSUM_EN
        , S_GET_CHK = 3'd7
`endif
    } state_t;

    state_t                  state, state_nxt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [LAT_W-1:0]        lat_cnt;
    logic                    start_q;
    logic [N_DATA-1:0]       alu_a, alu_b, tx_data;
    logic [NB_OPERATION-1:0] alu_op;
    logic [7:0]              err_cnt;
    logic                    in_get, rx_pop, tmo_hit, done_ok, err_inc;
`ifdef ALU_SEQ_CHECKSUM_EN
    logic                    chk_ok;
    assign chk_ok = (bus.i_rx_data == (alu_a ^ alu_b ^ N_DATA'(alu_op)));
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (rx_pop && bus.i_rx_data == SYNC_BYTE) state_nxt = S_GET_A;
            S_GET_A:  if (rx_pop) state_nxt = S_GET_B;  else if (tmo_hit) state_nxt = S_IDLE;
            S_GET_B:  if (rx_pop) state_nxt = S_GET_OP; else if (tmo_hit) state_nxt = S_IDLE;
`ifdef ALU_SEQ_CHECKSUM_EN
            S_GET_OP:  if (rx_pop) state_nxt = S_GET_CHK; else if (tmo_hit) state_nxt = S_IDLE;
            S_GET_CHK: begin
                if (rx_pop)       state_nxt = chk_ok ? S_EXEC : S_SEND_STAT;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
`else
            S_GET_OP:  if (rx_pop) state_nxt = S_EXEC; else if (tmo_hit) state_nxt = S_IDLE;
`endif
            S_EXEC:      if (lat_cnt == '0) state_nxt = S_SEND_RES;
            S_SEND_RES:  if (done_ok) state_nxt = S_SEND_STAT;
            S_SEND_STAT: if (done_ok) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_get = 1'b0;
        case (state)
            S_GET_A, S_GET_B, S_GET_OP: in_get = 1'b1;
`ifdef ALU_SEQ_CHECKSUM_EN
            S_GET_CHK:                  in_get = 1'b1;
`endif
            default:                    in_get = 1'b0;
        endcase
        rx_pop  = (in_get || state == S_IDLE) && !bus.i_rx_empty && !i_rst;
        tmo_hit = in_get && bus.i_rx_empty && (tmo_cnt == '0);
        // start_q marks the entry cycle; a done pulse there belongs to no byte yet
        done_ok = bus.i_tx_done && !start_q && (state == S_SEND_RES || state == S_SEND_STAT);
        err_inc = tmo_hit;
`ifdef ALU_SEQ_CHECKSUM_EN
        if (state == S_GET_CHK && rx_pop && !chk_ok) err_inc = 1'b1;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt <= '0;
            lat_cnt <= '0;
            start_q <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            tx_data <= '0;
            err_cnt <= '0;
        end else begin
            start_q <= (state_nxt != state) &&
                       (state_nxt == S_SEND_RES || state_nxt == S_SEND_STAT);
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            // inter-byte timer: reloaded outside GET_* and on every accepted byte
            if (!in_get || rx_pop || tmo_hit) tmo_cnt <= TMO_LOAD;
            else                              tmo_cnt <= tmo_cnt - TMO_W'(1);
            case (state)
                S_GET_A: if (rx_pop) alu_a <= bus.i_rx_data;
                S_GET_B: if (rx_pop) alu_b <= bus.i_rx_data;
                S_GET_OP: begin
                    if (rx_pop) begin
                        alu_op  <= bus.i_rx_data[NB_OPERATION-1:0];
                        lat_cnt <= LAT_LOAD;
                    end
                end
`ifdef ALU_SEQ_CHECKSUM_EN
                S_GET_CHK: if (rx_pop && !chk_ok) tx_data <= N_DATA'(1);
`endif
                S_EXEC: begin
                    if (lat_cnt == '0) tx_data <= bus.i_alu_data;
                    else               lat_cnt <= lat_cnt - LAT_W'(1);
                end
                S_SEND_RES: if (done_ok) tx_data <= '0;
                default: ;
            endcase
        end
    end

    assign bus.o_rx_read     = rx_pop;
    assign bus.o_alu_data_a  = alu_a;
    assign bus.o_alu_data_b  = alu_b;
    assign bus.o_alu_data_op = alu_op;
    assign bus.o_tx_data     = tx_data;
    assign bus.o_tx_start    = start_q;
    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_err_count   = err_cnt;
endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Framed-command controller that sits between the UART RX/TX FIFOs and the ALU. It pops a sync byte and the A, B and OP bytes from the RX FIFO, then drives the ALU operands. After a fixed ALU latency it captures the result and transmits a result byte and a status byte through the UART TX handshake. It replaces free-running byte-to-operand mapping with a framed protocol that has resynchronisation, inter-byte timeout and error counting.

## Interface
- N_DATA, 8, data/operand width in bits
- NB_OPERATION, 6, ALU opcode width in bits (≤ N_DATA)
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000, max idle cycles between bytes inside a frame (≥ 2)
- ALU_LATENCY, 1, cycles from operand update to valid i_alu_data (≥ 1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_rx_data  in  N_DATA  head of RX FIFO, valid when i_rx_empty=0
- i_rx_empty  in  1  RX FIFO empty
- o_rx_read  out  1  pop RX FIFO this cycle
- o_alu_data_a  out  N_DATA  operand A, registered
- o_alu_data_b  out  N_DATA  operand B, registered
- o_alu_data_op  out  NB_OPERATION  opcode, registered
- i_alu_data  in  N_DATA  ALU result
- o_tx_data  out  N_DATA  byte to transmit, held stable until i_tx_done
- o_tx_start  out  1  one-cycle transmit request
- i_tx_done  in  1  one-cycle pulse, byte sent
- o_busy  out  1  high in every state except IDLE
- o_err_count  out  8  saturating count of aborted or rejected frames

## Operation
- States: IDLE, GET_A, GET_B, GET_OP, [GET_CHK], EXEC, SEND_RES, SEND_STAT.
- o_rx_read = (state ∈ {IDLE, GET_A, GET_B, GET_OP, GET_CHK}) & ~i_rx_empty. This output is combinational; a byte is consumed in the same cycle it is read.
- IDLE: every popped byte is compared to SYNC_BYTE. A match moves to GET_A. Any other byte is discarded with no error.
- GET_A, GET_B: the popped byte is written to o_alu_data_a / o_alu_data_b. A byte equal to SYNC_BYTE is treated as data; there is no resync mid-frame.
- GET_OP: o_alu_data_op <= i_rx_data[NB_OPERATION-1:0], then go to GET_CHK if the macro is enabled, otherwise to EXEC.
- EXEC: count ALU_LATENCY cycles, then latch i_alu_data into o_tx_data and go to SEND_RES.
- SEND_RES: on the entry cycle pulse o_tx_start, then wait for i_tx_done. On i_tx_done set o_tx_data <= 8'h00 (status OK) and go to SEND_STAT.
- SEND_STAT: on the entry cycle pulse o_tx_start. On i_tx_done go to IDLE.
- Timeout:
  - The counter is cleared on every accepted byte and on entry to GET_A. It increments in the GET_* states while i_rx_empty=1.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, increment o_err_count, transmit nothing. Operand registers keep their partial values.
  - If a byte arrives in the cycle the count would expire, the byte is accepted and no timeout occurs.
- o_err_count saturates at 8'hFF.
- In EXEC, SEND_RES and SEND_STAT no bytes are popped. Following frames stay in the FIFO.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-frame or mid-transmit aborts immediately. No further o_tx_start is issued, and o_err_count is cleared.
- Latency, last frame byte to first o_tx_start: 1 (state change) + ALU_LATENCY + 1 cycles.
- o_tx_start is high only on the first cycle of SEND_RES / SEND_STAT.
- i_tx_done is ignored in the o_tx_start cycle and in every state other than SEND_RES / SEND_STAT.
- At most one RX byte is consumed per cycle.
- Back-to-back frames with no gap are supported. IDLE can pop a sync byte in the cycle after the SEND_STAT exit.

## Configuration
- ALU_SEQ_CHECKSUM_EN defined:
  - GET_CHK pops one more byte and compares it to A ^ B ^ {zero-extended OP}.
  - On a match, go to EXEC.
  - On a mismatch, load o_tx_data <= 8'h01, increment o_err_count and go straight to SEND_STAT, skipping EXEC and SEND_RES. Only the status byte is sent.
  - The timeout also applies in GET_CHK.
- ALU_SEQ_CHECKSUM_EN not defined:
  - The GET_CHK state and the comparison logic are absent.
  - A frame is SYNC, A, B, OP.
  - The status byte is always 8'h00.

## Test plan
- Nominal frame (checksum off): FIFO holds A5,12,34,20 and the ALU model is ADD. Required: o_alu_data_a=12, o_alu_data_b=34, o_alu_data_op=20, TX sends 46 then 00, o_err_count=0.
- Garbage before sync: FIFO holds 00,FF,A5,12,34,20. Required: 00 and FF are discarded with no error, result 46 and status 00 are sent.
- Timeout: send A5,12, then starve the FIFO for TIMEOUT_CYCLES cycles. Required: back in IDLE, o_err_count=1, no o_tx_start. A following valid frame completes normally.
- Checksum (macro on):
  - Frame A5,12,34,20,06: TX sends 46 then 00.
  - Frame A5,12,34,20,07: TX sends only 01, o_err_count increments.
- Back-to-back frames: two complete frames pushed at once, with i_tx_done delayed 50 cycles. Required: no RX pops during EXEC or either SEND state, both frames answered in order, exactly 4 o_tx_start pulses.
- Reset during SEND_RES: assert i_rst before i_tx_done arrives. Required: all outputs 0 in the next cycle, no SEND_STAT pulse, o_busy=0.
